// File: rtl/vga_frame_updater.sv
// vga_frame_updater: write master for the VGA sprite renderer.
// It loads both sprite bitmaps after reset. After that it rewrites the spaceship and
// planet positions once per vertical blank. Each register write is a three-cycle
// SETUP/STROBE/HOLD slot on the wren/addr/ldr port. The output port is registered,
// so it shows the slot decoded from the sequencer state one cycle earlier.
module vga_frame_updater #(
    parameter logic [255:0] SHIP_BITMAP   = 256'h0,
    parameter logic [255:0] PLANET_BITMAP = 256'h0,
    parameter int           SHIP_STEP     = 4,
    parameter int           PLANET_STEP   = 1,
    parameter int           SHIP_X0       = 312,
    parameter int           SHIP_Y0       = 232,
    parameter int           PLANET_X0     = 0,
    parameter int           PLANET_Y0     = 64
) (
    input  logic        clk_50Mhz,
    input  logic        rst_n,
    input  logic        move_valid,
    input  logic [1:0]  move_dir,
    input  logic        IRQ_Vsync,
    output logic        wren,
    output logic [5:0]  addr,
    output logic [15:0] ldr,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    typedef enum logic [1:0] {INIT, POSW, WAIT, CALC} state_t;
    typedef enum logic [1:0] {SETUP, STROBE, HOLD} phase_t;

    localparam logic signed [10:0] STEP_S  = 11'(SHIP_STEP);
    localparam logic signed [10:0] X_MAX   = 11'sd624;
    localparam logic signed [10:0] Y_MAX   = 11'sd464;
    localparam logic [10:0]        P_LIMIT = 11'd624;
    localparam logic [10:0]        P_SPAN  = 11'd625;
    localparam logic [10:0]        P_STEP  = 11'(PLANET_STEP);

    state_t             state, state_next;
    phase_t             phase;
    logic [4:0]         slot;
    logic               irq_s1, irq_s2, irq_s3, irq_rise;
    logic [3:0]         pend;
    logic signed [10:0] ship_x, ship_y;
    logic signed [10:0] ship_dx, ship_dy, sum_x, sum_y;
    logic signed [10:0] ship_x_calc, ship_y_calc;
    logic [9:0]         planet_x, planet_y, planet_x_calc;
    logic [10:0]        planet_sum;
    logic               wren_d, busy_d;
    logic [5:0]         addr_d;
    logic [15:0]        ldr_d;

    assign irq_rise = irq_s2 & ~irq_s3;

    // Bring the asynchronous vblank flag into the clock domain and keep one extra stage for edge detection
    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            irq_s1 <= 1'b0;
            irq_s2 <= 1'b0;
            irq_s3 <= 1'b0;
        end else begin
            irq_s1 <= IRQ_Vsync;
            irq_s2 <= irq_s1;
            irq_s3 <= irq_s2;
        end
    end

    // Sequencer state, slot counters, positions, pending move flags and frame counter
    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            state     <= INIT;
            phase     <= SETUP;
            slot      <= '0;
            ship_x    <= 11'(SHIP_X0);
            ship_y    <= 11'(SHIP_Y0);
            planet_x  <= 10'(PLANET_X0);
            planet_y  <= 10'(PLANET_Y0);
            pend      <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase <= SETUP;
                slot  <= '0;
            end else if (state == INIT || state == POSW) begin
                case (phase)
                    SETUP:   phase <= STROBE;
                    STROBE:  phase <= HOLD;
                    default: begin
                        phase <= SETUP;
                        slot  <= slot + 5'd1;
                    end
                endcase
            end
            if (state == CALC) begin
                ship_x   <= ship_x_calc;
                ship_y   <= ship_y_calc;
                planet_x <= planet_x_calc;
                pend     <= move_valid ? (4'b0001 << move_dir) : 4'b0000;
            end else if (move_valid) begin
                pend[move_dir] <= 1'b1;
            end
            if (state == POSW && phase == HOLD && slot == 5'd3) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Next-state decode: bitmap load, position writes, vblank wait, one-cycle position update
    always_comb begin
        state_next = state;
        case (state)
            INIT:    if (phase == HOLD && slot == 5'd31) state_next = POSW;
            POSW:    if (phase == HOLD && slot == 5'd3)  state_next = WAIT;
            WAIT:    if (irq_rise)                       state_next = CALC;
            default: state_next = POSW;
        endcase
    end

    // New positions from the pending flags: opposing moves cancel, ship clamps, planet wraps
    always_comb begin
        ship_dx = '0;
        ship_dy = '0;
        if (pend[2] && !pend[3]) begin
            ship_dx = -STEP_S;
        end else if (pend[3] && !pend[2]) begin
            ship_dx = STEP_S;
        end
        if (pend[0] && !pend[1]) begin
            ship_dy = -STEP_S;
        end else if (pend[1] && !pend[0]) begin
            ship_dy = STEP_S;
        end
        sum_x = ship_x + ship_dx;
        sum_y = ship_y + ship_dy;
        ship_x_calc = sum_x;
        if (sum_x < 11'sd0) begin
            ship_x_calc = '0;
        end else if (sum_x > X_MAX) begin
            ship_x_calc = X_MAX;
        end
        ship_y_calc = sum_y;
        if (sum_y < 11'sd0) begin
            ship_y_calc = '0;
        end else if (sum_y > Y_MAX) begin
            ship_y_calc = Y_MAX;
        end
        planet_sum    = {1'b0, planet_x} + P_STEP;
        planet_x_calc = (planet_sum > P_LIMIT) ? 10'(planet_sum - P_SPAN) : planet_sum[9:0];
    end

    // Output decode for the current slot; outside a sequence the port holds its last values
    always_comb begin
        wren_d = 1'b0;
        addr_d = addr;
        ldr_d  = ldr;
        busy_d = (state != WAIT);
        case (state)
            INIT: begin
                wren_d = (phase == STROBE);
                addr_d = {1'b0, slot};
                ldr_d  = slot[4] ? PLANET_BITMAP[{slot[3:0], 4'b0000} +: 16]
                                 : SHIP_BITMAP[{slot[3:0], 4'b0000} +: 16];
            end
            POSW: begin
                wren_d = (phase == STROBE);
                addr_d = 6'h20 | {4'b0000, slot[1:0]};
                case (slot[1:0])
                    2'd0:    ldr_d = {6'b0, ship_x[9:0]};
                    2'd1:    ldr_d = {6'b0, ship_y[9:0]};
                    2'd2:    ldr_d = {6'b0, planet_x};
                    default: ldr_d = {6'b0, planet_y};
                endcase
            end
            default: ;
        endcase
    end

    // Register the renderer port so reset forces it low on the very next cycle
    always_ff @(posedge clk_50Mhz) begin
        if (!rst_n) begin
            wren <= 1'b0;
            addr <= '0;
            ldr  <= '0;
            busy <= 1'b0;
        end else begin
            wren <= wren_d;
            addr <= addr_d;
            ldr  <= ldr_d;
            busy <= busy_d;
        end
    end

endmodule

// File: tb/tb_vga_frame_updater.sv
// tb_vga_frame_updater: scoreboard bench for vga_frame_updater.
// Stimulus pushes the expected register writes into a queue. A monitor pops one entry per
// wren pulse and compares addr/ldr. It also checks slot spacing and hold stability.
module tb_vga_frame_updater;

    typedef struct packed {
        logic [5:0]  a;
        logic [15:0] d;
    } wr_t;

    localparam logic [255:0] SHIP_BM =
        256'hF5A0_E5A1_D5A2_C5A3_B5A4_A5A5_95A6_85A7_75A8_65A9_55AA_45AB_35AC_25AD_15AE_05AF;
    localparam logic [255:0] PLANET_BM =
        256'h0C3F_1C3E_2C3D_3C3C_4C3B_5C3A_6C39_7C38_8C37_9C36_AC35_BC34_CC33_DC32_EC31_FC30;

    logic        clk_50Mhz;
    logic        rst_n;
    logic        move_valid;
    logic [1:0]  move_dir;
    logic        IRQ_Vsync;
    logic        wren;
    logic [5:0]  addr;
    logic [15:0] ldr;
    logic        busy;
    logic [7:0]  frame_cnt;

    wr_t         expQ[$];
    int          assertCount = 0;
    int          failCount = 0;
    int          cycle = 0;
    int          lastPulseCycle = 0;
    logic [5:0]  lastPulseAddr = '0;
    logic        wrenPrev = 1'b0;
    logic [5:0]  lastAddr = '0;
    logic [15:0] lastLdr = '0;

    vga_frame_updater #(
        .SHIP_BITMAP  (SHIP_BM),
        .PLANET_BITMAP(PLANET_BM),
        .SHIP_STEP    (4),
        .PLANET_STEP  (1),
        .SHIP_X0      (6),
        .SHIP_Y0      (458),
        .PLANET_X0    (621),
        .PLANET_Y0    (64)
    ) dut (
        .clk_50Mhz (clk_50Mhz),
        .rst_n     (rst_n),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .IRQ_Vsync (IRQ_Vsync),
        .wren      (wren),
        .addr      (addr),
        .ldr       (ldr),
        .busy      (busy),
        .frame_cnt (frame_cnt)
    );

    // Free-running 50 MHz-style clock
    initial clk_50Mhz = 1'b0;
    always #10 clk_50Mhz = ~clk_50Mhz;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] dir);
        @(negedge clk_50Mhz);
        move_valid = 1'b1;
        move_dir   = dir;
        @(negedge clk_50Mhz);
        move_valid = 1'b0;
    endtask

    task automatic pushInit();
        logic [3:0] rr;
        for (int r = 0; r < 16; r++) begin
            rr = 4'(r);
            expQ.push_back('{a: {2'b00, rr}, d: {rr, 8'h5A, ~rr}});
        end
        for (int r = 0; r < 16; r++) begin
            rr = 4'(r);
            expQ.push_back('{a: {2'b01, rr}, d: {~rr, 8'hC3, rr}});
        end
    endtask

    task automatic pushPos(input int sx, input int sy, input int px, input int py);
        expQ.push_back('{a: 6'h20, d: 16'(sx)});
        expQ.push_back('{a: 6'h21, d: 16'(sy)});
        expQ.push_back('{a: 6'h22, d: 16'(px)});
        expQ.push_back('{a: 6'h23, d: 16'(py)});
    endtask

    // Optionally raise vblank, wait for the sequence, count busy cycles, then check the frame counter
    task automatic runFrame(input bit raiseIrq, input bit toggleIrq, input bit moveInCalc,
                            input logic [1:0] calcDir, input int expBusy, input logic [7:0] expFc);
        int n;
        int busyCycles;
        if (raiseIrq) begin
            @(negedge clk_50Mhz);
            IRQ_Vsync = 1'b1;
            if (moveInCalc) begin
                repeat (3) @(posedge clk_50Mhz);
                @(negedge clk_50Mhz);
                move_valid = 1'b1;
                move_dir   = calcDir;
                @(negedge clk_50Mhz);
                move_valid = 1'b0;
            end
        end
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk_50Mhz);
            n++;
        end
        checkOutput("busy_start", 32'(busy), 32'd1);
        IRQ_Vsync  = 1'b0;
        move_valid = 1'b0;
        busyCycles = 0;
        while (busy === 1'b1 && busyCycles < 200) begin
            busyCycles++;
            if (toggleIrq && busyCycles == 4) IRQ_Vsync = 1'b1;
            @(negedge clk_50Mhz);
        end
        checkOutput("busy_cycles", 32'(busyCycles), 32'(expBusy));
        checkOutput("frame_cnt", 32'(frame_cnt), 32'(expFc));
        checkOutput("writes_outstanding", 32'(expQ.size()), 32'd0);
        IRQ_Vsync = 1'b0;
    endtask

    // Monitor: compare each write pulse against the scoreboard and check slot timing
    always @(negedge clk_50Mhz) begin : monitor
        wr_t e;
        cycle++;
        if (wrenPrev === 1'b1) begin
            checkOutput("hold_addr", 32'(addr), 32'(lastAddr));
            checkOutput("hold_ldr", 32'(ldr), 32'(lastLdr));
        end
        if (wren === 1'b1) begin
            checkOutput("wren_single", 32'(wrenPrev), 32'd0);
            if (addr != 6'h00 && (addr != 6'h20 || lastPulseAddr == 6'h1F)) begin
                checkOutput("pulse_spacing", 32'(cycle - lastPulseCycle), 32'd3);
            end
            if (expQ.size() == 0) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL unexpected_write: got addr 0x%0h ldr 0x%0h, expected no write", addr, ldr);
            end else begin
                e = expQ.pop_front();
                checkOutput("write_addr", 32'(addr), 32'(e.a));
                checkOutput("write_ldr", 32'(ldr), 32'(e.d));
            end
            lastPulseCycle = cycle;
            lastPulseAddr  = addr;
        end
        wrenPrev = wren;
        lastAddr = addr;
        lastLdr  = ldr;
    end

    // Safety net so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed frame sequence
    initial begin
        int n;
        int idleBusy;
        rst_n      = 1'b0;
        move_valid = 1'b0;
        move_dir   = 2'b00;
        IRQ_Vsync  = 1'b0;
        repeat (3) @(posedge clk_50Mhz);
        @(negedge clk_50Mhz);
        checkOutput("reset_wren", 32'(wren), 32'd0);
        checkOutput("reset_addr", 32'(addr), 32'd0);
        checkOutput("reset_ldr", 32'(ldr), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_frame_cnt", 32'(frame_cnt), 32'd0);

        pushInit();
        pushPos(6, 458, 621, 64);
        rst_n = 1'b1;
        runFrame(1'b0, 1'b0, 1'b0, 2'b00, 108, 8'd1);

        applyStimulus(2'b11);
        applyStimulus(2'b11);
        pushPos(10, 458, 622, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd2);

        applyStimulus(2'b10);
        applyStimulus(2'b01);
        pushPos(6, 462, 623, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd3);

        applyStimulus(2'b10);
        applyStimulus(2'b01);
        pushPos(2, 464, 624, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd4);

        applyStimulus(2'b10);
        applyStimulus(2'b00);
        applyStimulus(2'b01);
        pushPos(0, 464, 0, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd5);

        applyStimulus(2'b11);
        applyStimulus(2'b10);
        applyStimulus(2'b00);
        pushPos(0, 460, 1, 64);
        runFrame(1'b1, 1'b1, 1'b0, 2'b00, 13, 8'd6);
        idleBusy = 0;
        repeat (30) begin
            @(negedge clk_50Mhz);
            if (busy !== 1'b0) idleBusy++;
        end
        checkOutput("no_extra_sequence", 32'(idleBusy), 32'd0);
        checkOutput("frame_cnt_after_toggle", 32'(frame_cnt), 32'd6);

        pushPos(0, 460, 2, 64);
        runFrame(1'b1, 1'b0, 1'b1, 2'b11, 13, 8'd7);

        pushPos(4, 460, 3, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd8);

        pushPos(4, 460, 4, 64);
        @(negedge clk_50Mhz);
        IRQ_Vsync = 1'b1;
        n = 0;
        do begin
            @(posedge clk_50Mhz);
            n++;
        end while (expQ.size() != 2 && n < 100);
        checkOutput("abort_point_reached", 32'(expQ.size()), 32'd2);
        IRQ_Vsync = 1'b0;
        @(negedge clk_50Mhz);
        @(negedge clk_50Mhz);
        rst_n = 1'b0;
        @(negedge clk_50Mhz);
        checkOutput("abort_wren", 32'(wren), 32'd0);
        @(negedge clk_50Mhz);
        @(negedge clk_50Mhz);
        checkOutput("abort_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("abort_addr", 32'(addr), 32'd0);
        checkOutput("abort_ldr", 32'(ldr), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        expQ.delete();

        pushInit();
        pushPos(6, 458, 621, 64);
        rst_n      = 1'b1;
        move_valid = 1'b1;
        move_dir   = 2'b01;
        runFrame(1'b0, 1'b0, 1'b0, 2'b00, 108, 8'd1);

        pushPos(6, 462, 622, 64);
        runFrame(1'b1, 1'b0, 1'b0, 2'b00, 13, 8'd2);

        repeat (5) @(negedge clk_50Mhz);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
